// File: rtl/aresetn_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
//   seq_state_t : sequencer FSM encoding
//   cnt_width() : counter width large enough for the longer of the hold and gap intervals
package aresetn_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } seq_state_t;

  function automatic int unsigned cnt_width(input int unsigned hold_cyc,
                                            input int unsigned gap_cyc);
    int unsigned max_cyc;
    max_cyc = (hold_cyc > gap_cyc) ? hold_cyc : gap_cyc;
    return $clog2(max_cyc + 32'd1);
  endfunction

endpackage

// File: rtl/aresetn_seq_sync.sv
// Async-assert / sync-deassert reset synchroniser.
//   clk_i        : domain clock
//   arst_n_i     : raw asynchronous active-low reset
//   rst_sync_n_o : reset deasserted STAGES clock edges after arst_n_i rises
module aresetn_seq_sync #(
  parameter int unsigned STAGES = 3
) (
  input  logic clk_i,
  input  logic arst_n_i,
  output logic rst_sync_n_o
);

  logic [STAGES-1:0] sync_q;

  // Shift a constant 1 through the chain; any assertion clears every stage at once.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      sync_q <= {STAGES{1'b0}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], 1'b1};
    end
  end

  assign rst_sync_n_o = sync_q[STAGES-1];

endmodule

// File: rtl/aresetn_seq.sv
// Root reset sequencer for one clock domain.
// The synchronised reset is stretched by HOLD_CYC cycles, then the NUM_OUT outputs
// are released in ascending order GAP_CYC cycles apart. A soft-reset request
// drops all outputs and restarts the hold phase without touching ARESETN_I.
//   CLK_I      : domain clock
//   ARESETN_I  : asynchronous active-low reset
//   SRST_REQ_I : synchronous soft-reset request (level or pulse)
//   RESETN_O   : sequenced active-low resets, bit 0 released first
//   DONE_O     : high once every RESETN_O bit is released
module aresetn_seq
  import aresetn_seq_pkg::*;
#(
  parameter int unsigned STAGES   = 3,
  parameter int unsigned NUM_OUT  = 4,
  parameter int unsigned HOLD_CYC = 16,
  parameter int unsigned GAP_CYC  = 8
) (
  input  logic               CLK_I,
  input  logic               ARESETN_I,
  input  logic               SRST_REQ_I,
  output logic [NUM_OUT-1:0] RESETN_O,
  output logic               DONE_O
);

  localparam int unsigned CNT_W = cnt_width(HOLD_CYC, GAP_CYC);
  localparam int unsigned IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  // Counts compare against N-1 because the release happens on the N-th edge.
  localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0]   GAP_LAST  = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0]   CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0]   IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NUM_OUT - 1);
  localparam logic [NUM_OUT-1:0] OUT_ZERO  = {NUM_OUT{1'b0}};
  localparam logic [NUM_OUT-1:0] OUT_ONES  = {NUM_OUT{1'b1}};
  localparam logic [NUM_OUT-1:0] OUT_BIT0  = NUM_OUT'(1);

  logic               rst_sync_n_s;

  seq_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic [NUM_OUT-1:0] resetn_q, resetn_d;
  logic               done_q,  done_d;

  aresetn_seq_sync #(
    .STAGES(STAGES)
  ) u_sync (
    .clk_i       (CLK_I),
    .arst_n_i    (ARESETN_I),
    .rst_sync_n_o(rst_sync_n_s)
  );

  // Next-state logic for the hold/release sequencer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    resetn_d = resetn_q;
    done_d   = done_q;

    // Soft reset wins over any release scheduled on the same edge.
    if ((state_q != ST_ASSERT) && SRST_REQ_I) begin
      state_d  = ST_HOLD;
      cnt_d    = CNT_ZERO;
      idx_d    = IDX_ONE;
      resetn_d = OUT_ZERO;
      done_d   = 1'b0;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          if (rst_sync_n_s) begin
            state_d = ST_HOLD;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = ST_ASSERT;
          end
        end

        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            resetn_d = resetn_q | OUT_BIT0;
            cnt_d    = CNT_ZERO;
            idx_d    = IDX_ONE;
            if (NUM_OUT == 1) begin
              state_d = ST_RUN;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RELEASE;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        ST_RELEASE: begin
          if (cnt_q == GAP_LAST) begin
            resetn_d = resetn_q | (OUT_BIT0 << idx_q);
            cnt_d    = CNT_ZERO;
            if (idx_q == IDX_LAST) begin
              state_d = ST_RUN;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_q + IDX_ONE;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        ST_RUN: begin
          resetn_d = OUT_ONES;
          done_d   = 1'b1;
        end

        default: begin
          // Unreachable encoding: fall back to the fully-asserted state.
          state_d  = ST_ASSERT;
          cnt_d    = CNT_ZERO;
          idx_d    = IDX_ONE;
          resetn_d = OUT_ZERO;
          done_d   = 1'b0;
        end
      endcase
    end
  end

  // Sequencer state and output registers, all cleared asynchronously by ARESETN_I.
  always_ff @(posedge CLK_I or negedge ARESETN_I) begin
    if (!ARESETN_I) begin
      state_q  <= ST_ASSERT;
      cnt_q    <= CNT_ZERO;
      idx_q    <= IDX_ONE;
      resetn_q <= OUT_ZERO;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      resetn_q <= resetn_d;
      done_q   <= done_d;
    end
  end

  assign RESETN_O = resetn_q;
  assign DONE_O   = done_q;

endmodule

// File: tb/tb_aresetn_seq.sv
// Directed bench for aresetn_seq with STAGES=3, NUM_OUT=3, HOLD_CYC=4, GAP_CYC=2.
// Clock period is 4 time units; outputs are sampled 1 unit after each rising edge.
module tb_aresetn_seq;

  logic       CLK_I      = 1'b0;
  logic       ARESETN_I  = 1'b1;
  logic       SRST_REQ_I = 1'b0;
  logic [2:0] RESETN_O;
  logic       DONE_O;

  int total = 0;
  int bad   = 0;

  aresetn_seq #(
    .STAGES  (3),
    .NUM_OUT (3),
    .HOLD_CYC(4),
    .GAP_CYC (2)
  ) dut (
    .CLK_I     (CLK_I),
    .ARESETN_I (ARESETN_I),
    .SRST_REQ_I(SRST_REQ_I),
    .RESETN_O  (RESETN_O),
    .DONE_O    (DONE_O)
  );

  always #2 CLK_I = ~CLK_I;

  // Expected outputs k edges after a reference point where bit 0 is due at edge 'base'.
  function automatic logic [2:0] sched(input int k, input int base);
    logic [2:0] r;
    for (int i = 0; i < 3; i++) r[i] = (k >= base + 2 * i);
    return r;
  endfunction

  // Walk edges first_k..last_k and compare against the release schedule.
  task automatic run_schedule(input string tag, input int base,
                              input int first_k, input int last_k);
    logic [2:0] exp_v;
    logic       exp_d;
    for (int k = first_k; k <= last_k; k++) begin
      @(posedge CLK_I); #1;
      exp_v = sched(k, base);
      exp_d = (k >= base + 4);
      total++;
      if (RESETN_O !== exp_v) begin
        bad++;
        $display("FAIL %s resetn edge %0d: got %b want %b", tag, k, RESETN_O, exp_v);
      end
      total++;
      if (DONE_O !== exp_d) begin
        bad++;
        $display("FAIL %s done edge %0d: got %b want %b", tag, k, DONE_O, exp_d);
      end
    end
  endtask

  // Raise ARESETN_I one unit before the next rising edge (which becomes edge 1).
  task automatic rise_before_edge();
    @(negedge CLK_I); #1;
    ARESETN_I = 1'b1;
  endtask

  task automatic test_reset();
    #1 ARESETN_I = 1'b0;
    #1;
    total++;
    if (RESETN_O !== 3'b000) begin
      bad++;
      $display("FAIL reset resetn: got %b want 000", RESETN_O);
    end
    total++;
    if (DONE_O !== 1'b0) begin
      bad++;
      $display("FAIL reset done: got %b want 0", DONE_O);
    end
    repeat (2) @(posedge CLK_I);
  endtask

  task automatic test_power_up();
    rise_before_edge();
    run_schedule("powerup", 8, 1, 14);
  endtask

  task automatic test_async_assert();
    @(posedge CLK_I); #1;
    ARESETN_I = 1'b0;
    #1;
    total++;
    if (RESETN_O !== 3'b000 || DONE_O !== 1'b0) begin
      bad++;
      $display("FAIL async_assert clear: got resetn=%b done=%b want 000/0", RESETN_O, DONE_O);
    end
    repeat (3) @(posedge CLK_I);
    rise_before_edge();
    run_schedule("async_assert", 8, 1, 14);
  endtask

  task automatic test_glitch();
    @(posedge CLK_I); #1;
    ARESETN_I = 1'b0;
    #1;
    total++;
    if (RESETN_O !== 3'b000 || DONE_O !== 1'b0) begin
      bad++;
      $display("FAIL glitch clear: got resetn=%b done=%b want 000/0", RESETN_O, DONE_O);
    end
    ARESETN_I = 1'b1;
    run_schedule("glitch", 8, 1, 14);
  endtask

  task automatic test_soft_pulse();
    @(posedge CLK_I); #1;
    SRST_REQ_I = 1'b1;
    @(posedge CLK_I); #1;
    SRST_REQ_I = 1'b0;
    total++;
    if (RESETN_O !== 3'b000 || DONE_O !== 1'b0) begin
      bad++;
      $display("FAIL soft_pulse clear: got resetn=%b done=%b want 000/0", RESETN_O, DONE_O);
    end
    run_schedule("soft_pulse", 4, 1, 10);
  endtask

  task automatic test_soft_held();
    @(posedge CLK_I); #1;
    SRST_REQ_I = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(posedge CLK_I); #1;
      if (j == 4) SRST_REQ_I = 1'b0;
      total++;
      if (RESETN_O !== 3'b000 || DONE_O !== 1'b0) begin
        bad++;
        $display("FAIL soft_held cycle %0d: got resetn=%b done=%b want 000/0", j, RESETN_O, DONE_O);
      end
    end
    run_schedule("soft_held", 4, 1, 10);
  endtask

  task automatic test_soft_mid_release();
    @(posedge CLK_I); #1;
    ARESETN_I = 1'b0;
    repeat (2) @(posedge CLK_I);
    rise_before_edge();
    run_schedule("mid_pre", 8, 1, 9);
    SRST_REQ_I = 1'b1;
    @(posedge CLK_I); #1;
    SRST_REQ_I = 1'b0;
    total++;
    if (RESETN_O !== 3'b000 || DONE_O !== 1'b0) begin
      bad++;
      $display("FAIL mid_release edge 10: got resetn=%b done=%b want 000/0", RESETN_O, DONE_O);
    end
    run_schedule("mid_post", 14, 11, 20);
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_async_assert();
    test_glitch();
    test_soft_pulse();
    test_soft_held();
    test_soft_mid_release();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
